// File: rtl/imager_pkg.sv
// Shared types for the imager sequencer: FSM state, frame configuration record
// and the imager pattern-mode codes.
package imager_pkg;

  localparam int IMG_ROWS_W = 12;
  localparam int IMG_COLS_W = 12;
  localparam int IMG_FCNT_W = 16;
  localparam int IMG_MODE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_STREAM = 3'd2,
    ST_END    = 3'd3,
    ST_ERROR  = 3'd4
  } imager_state_e;

  typedef struct packed {
    logic [IMG_MODE_W-1:0] mode;
    logic [IMG_ROWS_W-1:0] active_rows;
    logic [IMG_ROWS_W-1:0] virtual_rows;
    logic [IMG_COLS_W-1:0] active_cols;
    logic [IMG_COLS_W-1:0] virtual_cols;
    logic [IMG_FCNT_W-1:0] num_frames;
  } imager_cfg_t;

  localparam logic [IMG_MODE_W-1:0] MODE_0 = 4'd0;
  localparam logic [IMG_MODE_W-1:0] MODE_1 = 4'd1;
  localparam logic [IMG_MODE_W-1:0] MODE_2 = 4'd2;
  localparam logic [IMG_MODE_W-1:0] MODE_3 = 4'd3;
  localparam logic [IMG_MODE_W-1:0] MODE_4 = 4'd4;
  localparam logic [IMG_MODE_W-1:0] MODE_5 = 4'd5;
  localparam logic [IMG_MODE_W-1:0] MODE_6 = 4'd6;
  localparam logic [IMG_MODE_W-1:0] MODE_7 = 4'd7;
  localparam logic [IMG_MODE_W-1:0] MODE_8 = 4'd8;

endpackage

// File: rtl/imager_seq_if.sv
// Capture-command channel between the host and the imager sequencer
// (valid/ready handshake plus the command fields).
interface imager_seq_if;
  import imager_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [IMG_FCNT_W-1:0] cmd_num_frames;
  logic [IMG_MODE_W-1:0] cmd_mode;
  logic [IMG_ROWS_W-1:0] cmd_active_rows;
  logic [IMG_ROWS_W-1:0] cmd_virtual_rows;
  logic [IMG_COLS_W-1:0] cmd_active_cols;
  logic [IMG_COLS_W-1:0] cmd_virtual_cols;

  modport master (
    output cmd_valid, cmd_num_frames, cmd_mode,
           cmd_active_rows, cmd_virtual_rows, cmd_active_cols, cmd_virtual_cols,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_num_frames, cmd_mode,
           cmd_active_rows, cmd_virtual_rows, cmd_active_cols, cmd_virtual_cols,
    output cmd_ready
  );

endinterface

// File: rtl/imager_seq_edge.sv
// Registers the imager frame-valid and produces registered rise/fall pulses
// that are aligned with the cycle in which fv_q_o takes its new value.
module imager_seq_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic fv_i,
  output logic fv_q_o,
  output logic rise_o,
  output logic fall_o
);

  logic fv_q;
  logic rise_q;
  logic fall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fv_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      fv_q   <= fv_i;
      rise_q <= fv_i & ~fv_q;
      fall_q <= ~fv_i & fv_q;
    end
  end

  assign fv_q_o = fv_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/imager_seq.sv
// Frame-aligned capture sequencer for the imager model. Optional watchdog is
// compiled in with IMAGER_SEQ_TIMEOUT_EN (default build: no watchdog).
module imager_seq
  import imager_pkg::*;
#(
  parameter int NUM_ROWS_WIDTH  = 12,
  parameter int NUM_COLS_WIDTH  = 12,
  parameter int FRAME_CNT_WIDTH = 16,
  parameter int TIMEOUT_WIDTH   = 24
) (
  input  logic                       clk,
  input  logic                       reset_n,
  imager_seq_if.slave                cmd,
  input  logic                       stop,
  input  logic [TIMEOUT_WIDTH-1:0]   timeout_cycles,
  input  logic                       fv,
  output logic                       img_enable,
  output logic [3:0]                 img_mode,
  output logic [NUM_ROWS_WIDTH-1:0]  img_num_active_rows,
  output logic [NUM_ROWS_WIDTH-1:0]  img_num_virtual_rows,
  output logic [NUM_COLS_WIDTH-1:0]  img_num_active_cols,
  output logic [NUM_COLS_WIDTH-1:0]  img_num_virtual_cols,
  output logic                       busy,
  output logic                       frame_start,
  output logic                       frame_done,
  output logic [FRAME_CNT_WIDTH-1:0] frames_captured,
  output logic                       done,
  output logic                       timeout_err
);

  function automatic logic [FRAME_CNT_WIDTH-1:0] sat_inc(input logic [FRAME_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  imager_state_e              state_q, state_d;
  imager_cfg_t                act_q, act_d;
  imager_cfg_t                pend_q, pend_d;
  logic                       pend_vld_q, pend_vld_d;
  logic [FRAME_CNT_WIDTH-1:0] fc_q, fc_d;
  logic                       err_q, err_d;

  logic fv_q, fv_rise, fv_fall;
  logic running, cmd_fire, target_hit, to_hit;
  logic [FRAME_CNT_WIDTH-1:0] fc_inc;

  imager_seq_edge u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .fv_i    (fv),
    .fv_q_o  (fv_q),
    .rise_o  (fv_rise),
    .fall_o  (fv_fall)
  );

  assign running       = (state_q == ST_ARM) || (state_q == ST_STREAM);
  assign cmd.cmd_ready = !pend_vld_q;
  assign cmd_fire      = cmd.cmd_valid && cmd.cmd_ready;
  assign fc_inc        = sat_inc(fc_q);
  assign target_hit    = (act_q.num_frames != '0) && (fc_inc >= act_q.num_frames);

`ifdef IMAGER_SEQ_TIMEOUT_EN
  // Watchdog measures time since the last fv edge while the imager is enabled.
  logic [TIMEOUT_WIDTH-1:0] to_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else if (!running || (fv != fv_q)) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign to_hit = running && (timeout_cycles != '0) && (to_cnt_q >= timeout_cycles - 1'b1);
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles;
  assign to_hit         = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    fc_d       = fc_q;
    err_d      = err_q;

    if (cmd_fire) begin
      pend_vld_d          = 1'b1;
      pend_d.mode         = cmd.cmd_mode;
      pend_d.active_rows  = cmd.cmd_active_rows;
      pend_d.virtual_rows = cmd.cmd_virtual_rows;
      pend_d.active_cols  = cmd.cmd_active_cols;
      pend_d.virtual_cols = cmd.cmd_virtual_cols;
      pend_d.num_frames   = cmd.cmd_num_frames;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_vld_q && !stop) begin
          act_d      = pend_q;
          pend_vld_d = 1'b0;
          fc_d       = '0;
          state_d    = ST_ARM;
        end
      end
      ST_ARM: begin
        if (stop)         state_d = ST_END;
        else if (to_hit)  state_d = ST_ERROR;
        else if (fv_rise) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        // Only leave between frames so the imager never sees a cut frame.
        if (fv_fall) begin
          fc_d = fc_inc;
          if (target_hit || stop || pend_vld_q) state_d = ST_END;
        end else if (to_hit) begin
          state_d = ST_ERROR;
        end else if ((stop || pend_vld_q) && !fv_q && !fv) begin
          state_d = ST_END;
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (pend_vld_q) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_ERROR && state_q != ST_ERROR) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      act_q      <= '0;
      pend_vld_q <= 1'b0;
      fc_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      pend_vld_q <= pend_vld_d;
      fc_q       <= fc_d;
      err_q      <= err_d;
    end
  end

  // Pending payload is qualified by pend_vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

  assign img_enable           = running;
  assign img_mode             = act_q.mode;
  assign img_num_active_rows  = act_q.active_rows;
  assign img_num_virtual_rows = act_q.virtual_rows;
  assign img_num_active_cols  = act_q.active_cols;
  assign img_num_virtual_cols = act_q.virtual_cols;
  assign busy                 = (state_q != ST_IDLE);
  assign frame_start          = fv_rise && ((state_q == ST_STREAM) ||
                                            ((state_q == ST_ARM) && (state_d == ST_STREAM)));
  assign frame_done           = fv_fall && (state_q == ST_STREAM);
  assign frames_captured      = fc_q;
  assign done                 = (state_q == ST_END);
  assign timeout_err          = err_q;

endmodule

// File: tb/tb_imager_seq.sv
// Self-checking bench for imager_seq with a behavioural imager model that
// produces fv frames from the programmed geometry.
module tb_imager_seq;
  import imager_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stop_tb, stop_auto, stop;
  logic [23:0] timeout_cycles;
  logic        fv;
  logic        img_enable, busy, frame_start, frame_done, done, timeout_err;
  logic [3:0]  img_mode;
  logic [11:0] img_num_active_rows, img_num_virtual_rows, img_num_active_cols, img_num_virtual_cols;
  logic [15:0] frames_captured;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imager_seq_if cmd_if ();

  assign stop = stop_tb | stop_auto;

  imager_seq u_dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .cmd                  (cmd_if),
    .stop                 (stop),
    .timeout_cycles       (timeout_cycles),
    .fv                   (fv),
    .img_enable           (img_enable),
    .img_mode             (img_mode),
    .img_num_active_rows  (img_num_active_rows),
    .img_num_virtual_rows (img_num_virtual_rows),
    .img_num_active_cols  (img_num_active_cols),
    .img_num_virtual_cols (img_num_virtual_cols),
    .busy                 (busy),
    .frame_start          (frame_start),
    .frame_done           (frame_done),
    .frames_captured      (frames_captured),
    .done                 (done),
    .timeout_err          (timeout_err)
  );

  // Imager model: 2 idle cycles after enable, then frames of
  // active_rows cycles with fv=1 followed by virtual_rows cycles with fv=0.
  int   ic = 0, nr = 0, nf = 0;
  int   stop_at_nf = -1;
  logic force_low = 1'b0;

  always @(negedge clk) begin
    logic nfv;
    int   hi, p;
    hi = int'(img_num_active_rows);
    p  = hi + int'(img_num_virtual_rows);
    if (!img_enable || p == 0) begin
      ic  = 0;
      nfv = 1'b0;
    end else begin
      nfv = (ic >= 2) && (((ic - 2) % p) < hi) && !force_low;
      ic++;
    end
    if (nfv && !fv) nr++;
    if (!nfv && fv) nf++;
    fv = nfv;
    stop_auto = (stop_at_nf >= 0) && (nf >= stop_at_nf);
  end

  // Pulse/edge monitor.
  int   cyc = 0, n_fs = 0, n_fd = 0, n_done = 0;
  int   last_fd_cyc = -10, en_fall_cyc = -20, low_cnt = 0, last_low = 0;
  logic done_at_fall = 1'b0, prev_en = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (frame_start) n_fs++;
    if (frame_done) begin n_fd++; last_fd_cyc = cyc; end
    if (done) n_done++;
    if (prev_en && !img_enable) begin en_fall_cyc = cyc; done_at_fall = done; end
    if (!img_enable) low_cnt++;
    else begin
      if (!prev_en) last_low = low_cnt;
      low_cnt = 0;
    end
    prev_en = img_enable;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "bench timeout");
  end

  task automatic send_cmd(input int nfr, input int mode, input int ar, input int vr,
                          input int ac, input int vc, output bit ok);
    int b = 0;
    @(negedge clk);
    while (!cmd_if.cmd_ready && b < 400) begin @(negedge clk); b++; end
    ok = cmd_if.cmd_ready;
    if (!ok) return;
    cmd_if.cmd_num_frames   = 16'(nfr);
    cmd_if.cmd_mode         = 4'(mode);
    cmd_if.cmd_active_rows  = 12'(ar);
    cmd_if.cmd_virtual_rows = 12'(vr);
    cmd_if.cmd_active_cols  = 12'(ac);
    cmd_if.cmd_virtual_cols = 12'(vc);
    cmd_if.cmd_valid        = 1'b1;
    @(negedge clk);
    cmd_if.cmd_valid        = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int b = 0;
    while (done !== 1'b1 && b < budget) begin @(negedge clk); b++; end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (img_enable !== 1'b0) begin errors++; $display("FAIL rst_img_enable: got %b want 0", img_enable); end
    checks++; if ({img_mode, img_num_active_rows, img_num_virtual_rows, img_num_active_cols, img_num_virtual_cols} !== 52'd0) begin
      errors++; $display("FAIL rst_img_cfg: got mode=%0d ar=%0d want all 0", img_mode, img_num_active_rows); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if ({frame_start, frame_done, done} !== 3'b000) begin errors++; $display("FAIL rst_pulses: got %b want 000", {frame_start, frame_done, done}); end
    checks++; if (frames_captured !== 16'd0) begin errors++; $display("FAIL rst_frames: got %0d want 0", frames_captured); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
    checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_if.cmd_ready); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_capture(input int nfr, input int mode, input int ar, input int vr, input int ac, input int vc);
    int b_fs, b_fd, b_done, b_nr, b_nf;
    bit ok;
    b_fs = n_fs; b_fd = n_fd; b_done = n_done; b_nr = nr; b_nf = nf;
    send_cmd(nfr, mode, ar, vr, ac, vc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cap_accept: cmd_ready never high"); end
    wait_done(4000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cap_done_wait: no done pulse within budget"); end
    checks++; if ({img_mode, img_num_active_rows, img_num_virtual_rows, img_num_active_cols, img_num_virtual_cols} !==
                  {4'(mode), 12'(ar), 12'(vr), 12'(ac), 12'(vc)}) begin
      errors++; $display("FAIL cap_cfg: got mode=%0d ar=%0d ac=%0d want mode=%0d ar=%0d ac=%0d",
                         img_mode, img_num_active_rows, img_num_active_cols, mode, ar, ac); end
    repeat (4) @(negedge clk);
    checks++; if (n_fs - b_fs != nfr) begin errors++; $display("FAIL cap_frame_start: got %0d want %0d", n_fs - b_fs, nfr); end
    checks++; if (n_fd - b_fd != nfr) begin errors++; $display("FAIL cap_frame_done: got %0d want %0d", n_fd - b_fd, nfr); end
    checks++; if (n_done - b_done != 1) begin errors++; $display("FAIL cap_done_count: got %0d want 1", n_done - b_done); end
    checks++; if (frames_captured !== 16'(nfr)) begin errors++; $display("FAIL cap_frames_captured: got %0d want %0d", frames_captured, nfr); end
    checks++; if (en_fall_cyc != last_fd_cyc + 1 || !done_at_fall) begin
      errors++; $display("FAIL cap_enable_fall: fall@%0d last_fd@%0d done_at_fall=%b want fall=last_fd+1 with done", en_fall_cyc, last_fd_cyc, done_at_fall); end
    checks++; if (nr - b_nr != nfr || nf - b_nf != nfr) begin
      errors++; $display("FAIL cap_imager_frames: rises=%0d falls=%0d want %0d each", nr - b_nr, nf - b_nf, nfr); end
  endtask

  task automatic test_stop();
    int b_done, b_nr, b_nf;
    bit ok;
    b_done = n_done; b_nr = nr; b_nf = nf;
    send_cmd(0, 2, 10, 5, 8, 4, ok);
    begin
      int b = 0;
      while (nr - b_nr < 2 && b < 400) begin @(negedge clk); b++; end
    end
    repeat (3) @(negedge clk);
    stop_tb = 1'b1;
    wait_done(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stop_done_wait: no done pulse within budget"); end
    checks++; if (frames_captured !== 16'd2) begin errors++; $display("FAIL stop_frames: got %0d want 2", frames_captured); end
    repeat (4) @(negedge clk);
    checks++; if (n_done - b_done != 1) begin errors++; $display("FAIL stop_done_count: got %0d want 1", n_done - b_done); end
    checks++; if (nr - b_nr != 2 || nf - b_nf != 2 || en_fall_cyc != last_fd_cyc + 1) begin
      errors++; $display("FAIL stop_no_cut: rises=%0d falls=%0d fall@%0d fd@%0d want 2/2 and fall=fd+1", nr - b_nr, nf - b_nf, en_fall_cyc, last_fd_cyc); end
    // stop still high: a new command must wait in the slot
    send_cmd(1, 4, 4, 4, 3, 3, ok);
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_blocks_busy: got %b want 0", busy); end
    checks++; if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL stop_blocks_ready: got %b want 0", cmd_if.cmd_ready); end
    stop_tb = 1'b0;
    wait_done(400, ok);
    checks++; if (!ok || frames_captured !== 16'd1) begin errors++; $display("FAIL stop_release_run: done=%b frames=%0d want 1 frame", ok, frames_captured); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int b_nr;
    bit ok;
    b_nr = nr;
    send_cmd(0, 3, 8, 4, 8, 4, ok);
    begin
      int b = 0;
      while (nr - b_nr < 1 && b < 400) begin @(negedge clk); b++; end
    end
    repeat (2) @(negedge clk);
    send_cmd(2, 7, 16, 4, 4, 4, ok);
    checks++; if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready: got %b want 0", cmd_if.cmd_ready); end
    wait_done(400, ok);
    checks++; if (!ok || frames_captured !== 16'd1 || img_mode !== 4'd3) begin
      errors++; $display("FAIL b2b_first_end: done=%b frames=%0d mode=%0d want 1 frame mode 3", ok, frames_captured, img_mode); end
    @(negedge clk);
    begin
      int b = 0;
      while (img_enable !== 1'b1 && b < 100) begin @(negedge clk); b++; end
    end
    checks++; if (img_enable !== 1'b1 || last_low < 1) begin errors++; $display("FAIL b2b_relaunch: enable=%b low_cycles=%0d want relaunch after >=1", img_enable, last_low); end
    checks++; if ({img_mode, img_num_active_rows, img_num_active_cols} !== {4'd7, 12'd16, 12'd4}) begin
      errors++; $display("FAIL b2b_cfg: got mode=%0d ar=%0d ac=%0d want 7 16 4", img_mode, img_num_active_rows, img_num_active_cols); end
    checks++; if (frames_captured !== 16'd0) begin errors++; $display("FAIL b2b_fresh_count: got %0d want 0", frames_captured); end
    wait_done(800, ok);
    checks++; if (!ok || frames_captured !== 16'd2) begin errors++; $display("FAIL b2b_second_run: done=%b frames=%0d want 2", ok, frames_captured); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_target_stop();
    int b_done;
    bit ok;
    b_done = n_done;
    stop_at_nf = nf + 2;
    send_cmd(2, 5, 6, 5, 2, 2, ok);
    wait_done(400, ok);
    checks++; if (!ok || frames_captured !== 16'd2) begin errors++; $display("FAIL tgt_stop_frames: done=%b frames=%0d want 2", ok, frames_captured); end
    repeat (10) @(negedge clk);
    checks++; if (n_done - b_done != 1) begin errors++; $display("FAIL tgt_stop_single_done: got %0d want 1", n_done - b_done); end
    stop_at_nf = -1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int b_nr, b_done;
    bit ok;
    b_nr = nr;
    send_cmd(0, 6, 10, 4, 5, 5, ok);
    begin
      int b = 0;
      while (nr - b_nr < 1 && b < 400) begin @(negedge clk); b++; end
    end
    repeat (2) @(negedge clk);
    send_cmd(3, 1, 8, 4, 8, 4, ok);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (img_enable !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_async: enable=%b busy=%b want 0 0", img_enable, busy); end
    checks++; if (cmd_if.cmd_ready !== 1'b1 || frames_captured !== 16'd0 || img_mode !== 4'd0 || img_num_active_rows !== 12'd0) begin
      errors++; $display("FAIL rmid_values: ready=%b frames=%0d mode=%0d ar=%0d want 1 0 0 0", cmd_if.cmd_ready, frames_captured, img_mode, img_num_active_rows); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    b_done = n_done;
    repeat (40) @(negedge clk);
    checks++; if (n_done != b_done || busy !== 1'b0 || img_enable !== 1'b0) begin
      errors++; $display("FAIL rmid_no_launch: dones=%0d busy=%b enable=%b want 0 0 0", n_done - b_done, busy, img_enable); end
  endtask

`ifdef IMAGER_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0, b = 0, b_done;
    bit ok;
    b_done = n_done;
    timeout_cycles = 24'd100;
    force_low = 1'b1;
    send_cmd(1, 2, 4, 4, 4, 4, ok);
    while (timeout_err !== 1'b1 && b < 400) begin
      if (img_enable) n++;
      @(negedge clk); b++;
    end
    checks++; if (timeout_err !== 1'b1 || n != 100) begin errors++; $display("FAIL to_trip: err=%b enabled_cycles=%0d want 1 100", timeout_err, n); end
    checks++; if (img_enable !== 1'b0 || n_done != b_done) begin errors++; $display("FAIL to_state: enable=%b dones=%0d want 0 0", img_enable, n_done - b_done); end
    force_low = 1'b0;
    send_cmd(1, 2, 4, 4, 4, 4, ok);
    repeat (3) @(negedge clk);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", timeout_err); end
    wait_done(400, ok);
    checks++; if (!ok || frames_captured !== 16'd1) begin errors++; $display("FAIL to_recover: done=%b frames=%0d want 1", ok, frames_captured); end
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    reset_n           = 1'b0;
    stop_tb           = 1'b0;
    timeout_cycles    = 24'd0;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_num_frames   = '0;
    cmd_if.cmd_mode         = '0;
    cmd_if.cmd_active_rows  = '0;
    cmd_if.cmd_virtual_rows = '0;
    cmd_if.cmd_active_cols  = '0;
    cmd_if.cmd_virtual_cols = '0;

    test_reset();
    test_capture(3, 1, 8, 4, 8, 4);
    for (int i = 0; i < 3; i++) begin
      test_capture(int'($urandom_range(1, 4)), int'($urandom_range(0, 8)), int'($urandom_range(2, 10)),
                   int'($urandom_range(4, 8)), int'($urandom_range(1, 15)), int'($urandom_range(0, 15)));
    end
    test_stop();
    test_back_to_back();
    test_target_stop();
    test_reset_mid();
`ifdef IMAGER_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
